// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the block-RAM round-robin arbiter.
// BRAM_ARB_OUTREG_EN selects the 2-cycle read latency variant.
package bram_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned MAX_REQ    = 4;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
      logic [DATA_W_DEF-1:0] mask;
   } req_t;

   // One-hot read tag, sized for the largest supported requester count
   typedef logic [MAX_REQ-1:0] tag_t;

   localparam logic [DATA_W_DEF-1:0] MASK_NONE = '1;

`ifdef BRAM_ARB_OUTREG_EN
   localparam int unsigned RD_LATENCY = 2;
`else
   localparam int unsigned RD_LATENCY = 1;
`endif

endpackage

// File: rtl/bram_rr_arbiter_if.sv
// Client-side request/response bundle for the block-RAM arbiter.
// master = requesters, slave = arbiter.
interface bram_rr_arbiter_if
   import bram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ*DATA_W-1:0] req_mask;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_mask,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_mask,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/bram_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// ascending with wrap-around.
module bram_arb_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   idx
);

   int unsigned cand;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = (32'(ptr) + i) % NUM_REQ;
         if (!found && valid[PTR_W'(cand)]) begin
            found                = 1'b1;
            grant[PTR_W'(cand)]  = 1'b1;
            idx                  = PTR_W'(cand);
         end
      end
   end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one 256x16 block RAM between NUM_REQ clients;
// reads are tagged and routed back. BRAM_ARB_OUTREG_EN adds an output stage.
module bram_rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   bram_rr_arbiter_if.slave   bus,
   output logic               ram_we,
   output logic               ram_re,
   output logic               ram_wclke,
   output logic               ram_rclke,
   output logic [ADDR_W-1:0]  ram_waddr,
   output logic [ADDR_W-1:0]  ram_raddr,
   output logic [DATA_W-1:0]  ram_wdata,
   output logic [DATA_W-1:0]  ram_mask,
   input  logic [DATA_W-1:0]  ram_rdata
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_d;
   logic [PTR_W-1:0]   idx;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] tag_q;
   logic               any_acc;
   req_t               req_a [NUM_REQ];
   req_t               sel;

   // Split the flat client buses into one request record per requester
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_a[g] = '{we:    bus.req_we[g],
                          addr:  bus.req_addr[g*ADDR_W +: ADDR_W],
                          wdata: bus.req_wdata[g*DATA_W +: DATA_W],
                          mask:  bus.req_mask[g*DATA_W +: DATA_W]};
   end

   bram_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .valid (bus.req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (idx)
   );

   // Nothing is accepted while reset is held
   assign any_acc       = (|grant) && !rst;
   assign bus.req_ready = rst ? '0 : grant;
   assign sel           = req_a[idx];

   always_comb begin
      ram_we    = 1'b0;
      ram_wclke = 1'b0;
      ram_re    = 1'b0;
      ram_rclke = 1'b0;
      ram_waddr = '0;
      ram_raddr = '0;
      ram_wdata = '0;
      ram_mask  = MASK_NONE;
      if (any_acc) begin
         if (sel.we) begin
            ram_we    = 1'b1;
            ram_wclke = 1'b1;
            ram_waddr = sel.addr;
            ram_wdata = sel.wdata;
            ram_mask  = sel.mask;
         end else begin
            ram_re    = 1'b1;
            ram_rclke = 1'b1;
            ram_raddr = sel.addr;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (any_acc) begin
         ptr_d = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         tag_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         tag_q <= (any_acc && !sel.we) ? grant : '0;
      end
   end

`ifdef BRAM_ARB_OUTREG_EN
   logic [NUM_REQ-1:0] vld2_q;
   logic [DATA_W-1:0]  rdata2_q;

   // Extra stage re-times the RAM data and its tag together
   always_ff @(posedge clk) begin
      if (rst) begin
         vld2_q   <= '0;
         rdata2_q <= '0;
      end else begin
         vld2_q   <= tag_q;
         rdata2_q <= ram_rdata;
      end
   end

   assign bus.rsp_valid = rst ? '0 : vld2_q;
   assign bus.rsp_rdata = rdata2_q;
`else
   assign bus.rsp_valid = rst ? '0 : tag_q;
   assign bus.rsp_rdata = ram_rdata;
`endif

endmodule
